// File: rtl/bfp16_accum.sv
// bfp16_accum: BFP16 (1/8/7) running-sum stage behind the PE multiplier.
// One result per dot product (closed by in_last), valid/ready on both sides.
// Optional: define BFP16_ACCUM_RNE_EN for round-to-nearest-even; the
// default build truncates toward zero.
module bfp16_accum #(
  parameter int BIAS  = 127,
  parameter int GUARD = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int SW  = 8 + GUARD;        // hidden 1 + 7 fraction + guard bits
  localparam int LZW = $clog2(SW + 1);
  localparam logic signed [9:0] EMAX = 10'(2 * BIAS);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t      state, state_nxt;
  logic [15:0] acc;
  logic [15:0] sum_res;
  logic        accept;

  // add datapath signals (acc is operand a, in_data is operand b)
  logic          a_nan, b_nan, a_inf, b_inf;
  logic [SW-1:0] ma, mb, m_big, m_sml, m_al, sh_mask;
  logic [7:0]    e_big, e_diff;
  logic          s_big, s_sml, s_res;
  logic [SW:0]   mag;
  logic [SW-1:0] mn;
  logic signed [9:0] e_n;
  logic [LZW-1:0] lz;
  logic          lz_found;
  logic [6:0]    frac;
`ifdef BFP16_ACCUM_RNE_EN
  logic          rnd_up;
  logic [8:0]    mant;
`else
  logic          unused_grs;
`endif

  assign out_valid = (state == HOLD);
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;

  // single-cycle BFP16 add: align, add/sub, normalise, round, specials
  always_comb begin
    a_nan = (&acc[14:7]) && (|acc[6:0]);
    b_nan = (&in_data[14:7]) && (|in_data[6:0]);
    a_inf = (&acc[14:7]) && !(|acc[6:0]);
    b_inf = (&in_data[14:7]) && !(|in_data[6:0]);
    // exponent 0 (zero or subnormal) flushes to a zero significand
    ma = (acc[14:7] == 8'd0)     ? '0 : {1'b1, acc[6:0], {GUARD{1'b0}}};
    mb = (in_data[14:7] == 8'd0) ? '0 : {1'b1, in_data[6:0], {GUARD{1'b0}}};
    if (acc[14:7] >= in_data[14:7]) begin
      m_big = ma; e_big = acc[14:7]; s_big = acc[15];
      m_sml = mb; s_sml = in_data[15];
      e_diff = acc[14:7] - in_data[14:7];
    end else begin
      m_big = mb; e_big = in_data[14:7]; s_big = in_data[15];
      m_sml = ma; s_sml = acc[15];
      e_diff = in_data[14:7] - acc[14:7];
    end
    // shifted-out bits collapse into the sticky LSB
    sh_mask = ~({SW{1'b1}} << e_diff);
    if (e_diff >= 8'(SW))
      m_al = {{(SW-1){1'b0}}, |m_sml};
    else
      m_al = (m_sml >> e_diff) | {{(SW-1){1'b0}}, |(m_sml & sh_mask)};
    if (s_big == s_sml) begin
      mag = {1'b0, m_big} + {1'b0, m_al};
      s_res = s_big;
    end else if (m_big >= m_al) begin
      mag = {1'b0, m_big - m_al};
      s_res = s_big;
    end else begin
      mag = {1'b0, m_al - m_big};
      s_res = s_sml;
    end
    lz = '0;
    lz_found = 1'b0;
    for (int i = SW - 1; i >= 0; i--) begin
      if (!lz_found && mag[i]) begin
        lz = LZW'(SW - 1 - i);
        lz_found = 1'b1;
      end
    end
    e_n = $signed({2'b00, e_big});
    if (mag[SW]) begin
      mn  = mag[SW:1] | {{(SW-1){1'b0}}, mag[0]};
      e_n = e_n + 10'sd1;
    end else begin
      mn  = mag[SW-1:0] << lz;
      e_n = e_n - $signed({{(10-LZW){1'b0}}, lz});
    end
`ifdef BFP16_ACCUM_RNE_EN
    rnd_up = mn[GUARD-1] & (mn[GUARD-2] | (|mn[GUARD-3:0]) | mn[GUARD]);
    mant   = {1'b0, mn[SW-1:GUARD]} + {8'd0, rnd_up};
    if (mant[8]) begin
      e_n  = e_n + 10'sd1;
      frac = '0;
    end else begin
      frac = mant[6:0];
    end
`else
    frac = mn[SW-2:GUARD];
    unused_grs = ^{mn[SW-1], mn[GUARD-1:0]};
`endif
    if (a_nan || b_nan || (a_inf && b_inf && (acc[15] != in_data[15])))
      sum_res = 16'h7FC0;
    else if (a_inf)
      sum_res = acc;
    else if (b_inf)
      sum_res = in_data;
    else if (mag == '0)
      sum_res = 16'h0000;
    else if (e_n > EMAX)
      sum_res = {s_res, 15'h7F80};
    else if (e_n < 10'sd1)
      sum_res = 16'h0000;
    else
      sum_res = {s_res, e_n[7:0], frac};
  end

  // next state: a last beat always (re)loads HOLD; drain returns to ACCUM
  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM: if (accept && in_last) state_nxt = HOLD;
      HOLD: begin
        if (accept && in_last) state_nxt = HOLD;
        else if (out_ready)    state_nxt = ACCUM;
      end
      default: state_nxt = ACCUM;
    endcase
  end

  // state, accumulator and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ACCUM;
      acc      <= 16'h0000;
      out_data <= 16'h0000;
    end else begin
      state <= state_nxt;
      if (accept) begin
        if (in_last) begin
          out_data <= sum_res;
          acc      <= 16'h0000;
        end else begin
          acc <= sum_res;
        end
      end
    end
  end

endmodule

// File: tb/tb_bfp16_accum.sv
// tb_bfp16_accum: directed cases plus random dot products against an
// integer-arithmetic reference of the BFP16 add rules.
module tb_bfp16_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_data;
  logic        in_valid, in_last, in_ready;
  logic [15:0] out_data;
  logic        out_valid, out_ready;

  int checks = 0;
  int errors = 0;

  bfp16_accum dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // present one beat for one clock; sample #1 after the edge
  task automatic send(input logic [15:0] d, input logic l);
    in_data = d; in_valid = 1'b1; in_last = l;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  // reference: exact integer significands with guard/sticky alignment
  function automatic logic [15:0] ref_add(input logic [15:0] a, input logic [15:0] b);
    int ea, eb, ma, mb, e1, e2, m1, m2, d, al, v, e, mag, keep;
    logic s1, s2, sg;
`ifdef BFP16_ACCUM_RNE_EN
    int low;
`endif
    ea = int'(a[14:7]); eb = int'(b[14:7]);
    if ((ea == 255 && a[6:0] != 0) || (eb == 255 && b[6:0] != 0)) return 16'h7FC0;
    if (ea == 255 && eb == 255) return (a[15] != b[15]) ? 16'h7FC0 : a;
    if (ea == 255) return a;
    if (eb == 255) return b;
    ma = (ea == 0) ? 0 : (128 + int'(a[6:0])) * 8;
    mb = (eb == 0) ? 0 : (128 + int'(b[6:0])) * 8;
    if (ea >= eb) begin
      e1 = ea; m1 = ma; s1 = a[15]; e2 = eb; m2 = mb; s2 = b[15];
    end else begin
      e1 = eb; m1 = mb; s1 = b[15]; e2 = ea; m2 = ma; s2 = a[15];
    end
    d = e1 - e2;
    if (d >= 11) al = (m2 != 0) ? 1 : 0;
    else al = (m2 / (1 << d)) | (((m2 % (1 << d)) != 0) ? 1 : 0);
    v = (s1 ? -m1 : m1) + (s2 ? -al : al);
    if (v == 0) return 16'h0000;
    sg = (v < 0);
    mag = sg ? -v : v;
    e = e1;
    while (mag >= 2048) begin mag = (mag / 2) | (mag % 2); e++; end
    while (mag < 1024) begin mag = mag * 2; e--; end
    keep = mag / 8;
`ifdef BFP16_ACCUM_RNE_EN
    low = mag % 8;
    if (low > 4 || (low == 4 && (keep % 2) == 1)) keep++;
    if (keep == 256) begin keep = 128; e++; end
`endif
    if (e > 254) return sg ? 16'hFF80 : 16'h7F80;
    if (e < 1) return 16'h0000;
    return {sg, 8'(e), 7'(keep)};
  endfunction

  function automatic logic [15:0] rnd_bf();
    int r;
    r = int'($urandom_range(0, 15));
    case (r)
      0: return ($urandom_range(0, 1) == 1) ? 16'h8000 : 16'h0000;
      1: return {1'($urandom_range(0, 1)), 8'd0, 7'($urandom_range(1, 127))};
      2: return ($urandom_range(0, 1) == 1) ? 16'hFF80 : 16'h7F80;
      3: return {1'($urandom_range(0, 1)), 8'hFF, 7'($urandom_range(1, 127))};
      default: return {1'($urandom_range(0, 1)), 8'($urandom_range(120, 135)), 7'($urandom_range(0, 127))};
    endcase
  endfunction

  initial begin
    logic [15:0] acc_m, x, exp_r;
    int len;
    rst = 1'b1; in_data = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 16'(out_valid), 16'd0);
    chk("rst_out_data", out_data, 16'h0000);
    chk("rst_in_ready", 16'(in_ready), 16'd1);
    rst = 1'b0;

    // 1+1+1 = 3
    send(16'h3F80, 1'b0);
    send(16'h3F80, 1'b0);
    chk("sum3_in_ready", 16'(in_ready), 16'd1);
    send(16'h3F80, 1'b1);
    chk("sum3_valid", 16'(out_valid), 16'd1);
    chk("sum3_data", out_data, 16'h4040);
    idle();
    chk("sum3_drained", 16'(out_valid), 16'd0);

    // exact cancellation, then acc must have been cleared
    send(16'hBF80, 1'b0);
    send(16'h3F80, 1'b1);
    chk("cancel", out_data, 16'h0000);
    send(16'h4000, 1'b1);
    chk("after_clear", out_data, 16'h4000);

    // guard bits: rounding vs truncation
    send(16'h3F80, 1'b0);
    send(16'h3BC0, 1'b1);
`ifdef BFP16_ACCUM_RNE_EN
    chk("round", out_data, 16'h3F81);
`else
    chk("round", out_data, 16'h3F80);
`endif

    // specials
    send(16'h7F80, 1'b0);
    send(16'hFF80, 1'b1);
    chk("inf_minus_inf", out_data, 16'h7FC0);
    send(16'h7F00, 1'b0);
    send(16'h7F00, 1'b1);
    chk("overflow", out_data, 16'h7F80);
    send(16'h7FC1, 1'b0);
    send(16'hFF80, 1'b0);
    send(16'h3F80, 1'b1);
    chk("nan_sticky", out_data, 16'h7FC0);
    send(16'h4000, 1'b1);
    chk("nan_cleared", out_data, 16'h4000);
    idle();

    // backpressure: result held, then no-bubble reload
    out_ready = 1'b0;
    send(16'h3F80, 1'b1);
    chk("stall_first", out_data, 16'h3F80);
    in_data = 16'h4040; in_valid = 1'b1; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("stall_in_ready", 16'(in_ready), 16'd0);
      @(posedge clk); #1;
      chk("stall_valid", 16'(out_valid), 16'd1);
      chk("stall_hold", out_data, 16'h3F80);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    chk("reload_valid", 16'(out_valid), 16'd1);
    chk("reload_data", out_data, 16'h4040);
    idle();
    chk("reload_drained", 16'(out_valid), 16'd0);

    // reset mid dot product; beat in reset cycle is dropped
    send(16'h3F80, 1'b0);
    send(16'h3F80, 1'b0);
    rst = 1'b1; in_data = 16'h3F80; in_valid = 1'b1; in_last = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    chk("midrst_valid", 16'(out_valid), 16'd0);
    chk("midrst_data", out_data, 16'h0000);
    send(16'h4000, 1'b1);
    chk("midrst_after", out_data, 16'h4000);

    // random back-to-back dot products against the reference
    for (int n = 0; n < 60; n++) begin
      len = int'($urandom_range(1, 6));
      acc_m = 16'h0000;
      for (int k = 0; k < len; k++) begin
        x = rnd_bf();
        chk("rand_in_ready", 16'(in_ready), 16'd1);
        if (k == len - 1) begin
          exp_r = ref_add(acc_m, x);
          send(x, 1'b1);
          chk("rand_valid", 16'(out_valid), 16'd1);
          chk("rand_data", out_data, exp_r);
        end else begin
          acc_m = ref_add(acc_m, x);
          send(x, 1'b0);
        end
      end
    end
    idle();
    chk("final_idle", 16'(out_valid), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
